alu_regfile_sequencer: RTL and testbench
========================================

Name: alu_regfile_sequencer

Overview:
- Multi-cycle execute controller that sequences the existing register file and ALU for a single-issue MIPS integer datapath.
- Accepts one 32-bit instruction per valid/ready handshake.
- Reads the source registers, drives the ALU operands and control lines, and writes the result back through the register-file write port.
- Sits between the future fetch/decode stage and the Register_File/ALU pair.

Parameters:
- DATA_W, 32, datapath width (ALU operands and register data).
- REG_AW, 5, register address width.
- ALU_CW, 4, ALU control-line width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered this cycle.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  32  MIPS R-type or I-type instruction word.
- rf_r_reg1  out  REG_AW  register-file read address 1 (rs).
- rf_r_reg2  out  REG_AW  register-file read address 2 (rt).
- rf_r_data1  in  DATA_W  read data 1, combinational from rf_r_reg1.
- rf_r_data2  in  DATA_W  read data 2, combinational from rf_r_reg2.
- rf_w_reg  out  REG_AW  write address.
- rf_w_data  out  DATA_W  write data.
- rf_ctrl_w  out  1  write enable, one-cycle pulse.
- alu_ctrl  out  ALU_CW  ALU control lines.
- alu_in1  out  DATA_W  ALU operand A.
- alu_in2  out  DATA_W  ALU operand B.
- alu_out  in  DATA_W  ALU result, combinational.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  qualifies done; instruction was not executed.

Behaviour:
- Reset: asynchronous, active-low. State goes to IDLE. All outputs are 0 except instr_ready=1. All internal latches are cleared.
- Reset asserted mid-operation aborts the instruction immediately with no write.
- State machine: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and decode it.
  - Legal instruction -> READ. Illegal instruction -> WB with illegal flag set.
  - While busy, instr_valid is ignored; instr need not be held.
- READ:
  - rf_r_reg1=rs[25:21], rf_r_reg2=rt[20:16].
  - Latch rf_r_data1 into opA and rf_r_data2 into opB at the end of the cycle.
- EXEC:
  - alu_in1=opA.
  - alu_in2=opB for R-type, or extended immediate for I-type.
  - alu_ctrl=decoded code.
  - Latch alu_out into res at the end of the cycle.
- WB:
  - rf_w_reg=dest, rf_w_data=res, done=1.
  - rf_ctrl_w=1 unless illegal or dest==0.
  - illegal=1 if illegal.
  - Next state is IDLE.
- Latency: accept at edge N; write/done during cycle N+3; instr_ready high again in cycle N+4. Throughput is one instruction per 4 cycles.
- The ALU and register-file read ports are driven only in their own states. Outside those states, the address, operand and ctrl outputs are 0.
- Decode, R-type (opcode 0x00), dest=rd[15:11]:
  - funct 0x20 add -> 0010
  - funct 0x22 sub -> 0110
  - funct 0x24 and -> 0000
  - funct 0x25 or -> 0001
  - funct 0x27 nor -> 1100
  - funct 0x2A slt -> 0111
- Decode, I-type, dest=rt[20:16]:
  - addi 0x08 -> 0010, sign-extended imm.
  - slti 0x0A -> 0111, sign-extended imm.
  - andi 0x0C -> 0000, zero-extended imm.
  - ori 0x0D -> 0001, zero-extended imm.
- Any other opcode, or any other funct with opcode 0x00, is illegal.
- Arithmetic: the ALU owns all overflow behaviour; the sequencer does not trap. shamt is ignored.
- A write to $0 completes with done=1, rf_ctrl_w=0, illegal=0.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants: OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI.
  - Funct constants: FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT.
  - ALU control constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR.
  - State enum seq_state_t.
- One natural sub-module: alu_decode. It is purely combinational: instr -> alu_ctrl, dest, use_imm, imm_ext, illegal. It is reused later by the ALU-control path.

Test Plan:
- Reset: rst_n low mid-EXEC of an add -> no rf_ctrl_w pulse, instr_ready=1, all other outputs 0 while low.
- R-type add: r1=2, r2=1, instr add $3,$1,$2 (0x00221820).
  - Required: rf_r_reg1=1, rf_r_reg2=2 in READ.
  - alu_ctrl=0010, alu_in1=2, alu_in2=1 in EXEC.
  - In WB: rf_w_reg=3, rf_w_data=3, rf_ctrl_w=1, done=1, exactly 3 cycles after accept.
- I-type extension:
  - addi $4,$1,-1 (0x2024FFFF) with r1=2 -> alu_in2=0xFFFFFFFF, write 1 to $4.
  - ori $5,$0,0x8000 -> alu_in2=0x00008000.
- $0 destination: add $0,$1,$2 -> done=1, rf_ctrl_w=0, illegal=0.
- Illegal: opcode 0x3F -> next cycle done=1, illegal=1, rf_ctrl_w=0; instr_ready back 2 cycles after accept.
- Back-to-back: instr_valid held high with 3 instructions -> accepts spaced exactly 4 cycles apart; valid ignored while instr_ready=0; all three writebacks correct and in order.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS integer-datapath definitions: opcodes, funct codes, ALU control
// codes, the execute-sequencer state type and immediate-extension helpers.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int ALU_CW = 4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [ALU_CW-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_CW-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_CW-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_CW-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_CW-1:0] ALU_SLT = 4'b0111;
   localparam logic [ALU_CW-1:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } seq_state_t;

   function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] v);
      return {{(DATA_W-16){v[15]}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] zero_ext16(input logic [15:0] v);
      return {{(DATA_W-16){1'b0}}, v};
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode: instruction word to ALU control code, register
// fields, destination, immediate operand and an illegal-instruction flag.
module alu_decode
   import mips_pkg::*;
(
   input  logic [31:0]       instr,
   output logic [ALU_CW-1:0] alu_ctrl,
   output logic [REG_AW-1:0] rs,
   output logic [REG_AW-1:0] rt,
   output logic [REG_AW-1:0] dest,
   output logic              use_imm,
   output logic [DATA_W-1:0] imm_ext,
   output logic              illegal
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];

   always_comb begin
      alu_ctrl = ALU_ADD;
      dest     = '0;
      use_imm  = 1'b0;
      imm_ext  = sign_ext16(imm);
      illegal  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dest = instr[15:11];
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_NOR:  alu_ctrl = ALU_NOR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: illegal  = 1'b1;
            endcase
         end
         OP_ADDI: begin
            dest     = instr[20:16];
            use_imm  = 1'b1;
            alu_ctrl = ALU_ADD;
         end
         OP_SLTI: begin
            dest     = instr[20:16];
            use_imm  = 1'b1;
            alu_ctrl = ALU_SLT;
         end
         // Logical immediates are zero-extended, arithmetic ones sign-extended.
         OP_ANDI: begin
            dest     = instr[20:16];
            use_imm  = 1'b1;
            alu_ctrl = ALU_AND;
            imm_ext  = zero_ext16(imm);
         end
         OP_ORI: begin
            dest     = instr[20:16];
            use_imm  = 1'b1;
            alu_ctrl = ALU_OR;
            imm_ext  = zero_ext16(imm);
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         dest     = '0;
         alu_ctrl = ALU_ADD;
         use_imm  = 1'b0;
      end
   end

endmodule

// File: rtl/alu_regfile_sequencer.sv
// Multi-cycle execute controller: accepts one instruction, reads the register
// file, drives the ALU and writes the result back (IDLE->READ->EXEC->WB).
module alu_regfile_sequencer
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   output logic [REG_AW-1:0] rf_r_reg1,
   output logic [REG_AW-1:0] rf_r_reg2,
   input  logic [DATA_W-1:0] rf_r_data1,
   input  logic [DATA_W-1:0] rf_r_data2,
   output logic [REG_AW-1:0] rf_w_reg,
   output logic [DATA_W-1:0] rf_w_data,
   output logic              rf_ctrl_w,
   output logic [ALU_CW-1:0] alu_ctrl,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   input  logic [DATA_W-1:0] alu_out,
   output logic              done,
   output logic              illegal
);

   logic [ALU_CW-1:0] dec_alu_ctrl;
   logic [REG_AW-1:0] dec_rs;
   logic [REG_AW-1:0] dec_rt;
   logic [REG_AW-1:0] dec_dest;
   logic              dec_use_imm;
   logic [DATA_W-1:0] dec_imm_ext;
   logic              dec_illegal;

   seq_state_t        state_reg;
   logic [ALU_CW-1:0] ctrl_reg;
   logic [REG_AW-1:0] dest_reg;
   logic              use_imm_reg;
   logic [DATA_W-1:0] imm_reg;

   alu_decode u_decode (
      .instr    (instr),
      .alu_ctrl (dec_alu_ctrl),
      .rs       (dec_rs),
      .rt       (dec_rt),
      .dest     (dec_dest),
      .use_imm  (dec_use_imm),
      .imm_ext  (dec_imm_ext),
      .illegal  (dec_illegal)
   );

   // alu_in1/alu_in2 double as the opA/opB latches: they are loaded from the
   // read ports at the end of READ and held for exactly the EXEC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         instr_ready <= 1'b1;
         rf_r_reg1   <= '0;
         rf_r_reg2   <= '0;
         rf_w_reg    <= '0;
         rf_w_data   <= '0;
         rf_ctrl_w   <= 1'b0;
         alu_ctrl    <= '0;
         alu_in1     <= '0;
         alu_in2     <= '0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         ctrl_reg    <= '0;
         dest_reg    <= '0;
         use_imm_reg <= 1'b0;
         imm_reg     <= '0;
      end else begin
         done      <= 1'b0;
         illegal   <= 1'b0;
         rf_ctrl_w <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (instr_valid) begin
                  instr_ready <= 1'b0;
                  ctrl_reg    <= dec_alu_ctrl;
                  dest_reg    <= dec_dest;
                  use_imm_reg <= dec_use_imm;
                  imm_reg     <= dec_imm_ext;
                  if (dec_illegal) begin
                     // Skip straight to a non-writing completion.
                     state_reg <= ST_WB;
                     done      <= 1'b1;
                     illegal   <= 1'b1;
                     rf_w_reg  <= '0;
                     rf_w_data <= '0;
                  end else begin
                     state_reg <= ST_READ;
                     rf_r_reg1 <= dec_rs;
                     rf_r_reg2 <= dec_rt;
                  end
               end
            end
            ST_READ: begin
               state_reg <= ST_EXEC;
               rf_r_reg1 <= '0;
               rf_r_reg2 <= '0;
               alu_ctrl  <= ctrl_reg;
               alu_in1   <= rf_r_data1;
               alu_in2   <= use_imm_reg ? imm_reg : rf_r_data2;
            end
            ST_EXEC: begin
               state_reg <= ST_WB;
               alu_ctrl  <= '0;
               alu_in1   <= '0;
               alu_in2   <= '0;
               rf_w_reg  <= dest_reg;
               rf_w_data <= alu_out;
               rf_ctrl_w <= (dest_reg != '0);
               done      <= 1'b1;
            end
            ST_WB: begin
               state_reg   <= ST_IDLE;
               instr_ready <= 1'b1;
               rf_w_reg    <= '0;
               rf_w_data   <= '0;
            end
            default: begin
               state_reg   <= ST_IDLE;
               instr_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// Scoreboard bench: a stimulus process issues instructions, an acceptor pushes
// model expectations, and a monitor checks each READ/EXEC/WB cycle in order.
module tb_alu_regfile_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = 32'h0;
   logic [4:0]  rf_r_reg1, rf_r_reg2, rf_w_reg;
   logic [31:0] rf_r_data1, rf_r_data2, rf_w_data;
   logic        rf_ctrl_w;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_in1, alu_in2, alu_out;
   logic        done, illegal;

   always #5 clk = ~clk;

   alu_regfile_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .rf_r_reg1   (rf_r_reg1),
      .rf_r_reg2   (rf_r_reg2),
      .rf_r_data1  (rf_r_data1),
      .rf_r_data2  (rf_r_data2),
      .rf_w_reg    (rf_w_reg),
      .rf_w_data   (rf_w_data),
      .rf_ctrl_w   (rf_ctrl_w),
      .alu_ctrl    (alu_ctrl),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_out     (alu_out),
      .done        (done),
      .illegal     (illegal)
   );

   // ---------------- environment: register file and ALU ----------------
   logic [31:0] regs [32];
   logic [31:0] init_vals [32];
   logic        load_en = 1'b0;

   assign rf_r_data1 = regs[rf_r_reg1];
   assign rf_r_data2 = regs[rf_r_reg2];

   always @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < 32; i++) regs[i] <= init_vals[i];
      end else if (rst_n && rf_ctrl_w && rf_w_reg != 5'd0) begin
         regs[rf_w_reg] <= rf_w_data;
      end
   end

   always_comb begin
      alu_out = 32'h0;
      case (alu_ctrl)
         4'b0010: alu_out = alu_in1 + alu_in2;
         4'b0110: alu_out = alu_in1 - alu_in2;
         4'b0000: alu_out = alu_in1 & alu_in2;
         4'b0001: alu_out = alu_in1 | alu_in2;
         4'b1100: alu_out = ~(alu_in1 | alu_in2);
         4'b0111: alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
         default: alu_out = 32'h0;
      endcase
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      int          acc;
      bit          legal;
      logic [4:0]  rs, rt, dest;
      logic [3:0]  ctrl;
      logic [31:0] a, b, val;
      bit          we;
   } exp_t;

   exp_t        q[$];
   exp_t        acc_e;
   exp_t        mon_h;
   logic [31:0] shadow [32];
   int          cyc = 0;
   int          n_acc = 0;
   int          acc_log[$];
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Architectural meaning of each instruction, expressed by mnemonic.
   function automatic exp_t model(input logic [31:0] w);
      exp_t        e;
      logic [31:0] a, rtv, se, ze;
      e.acc   = 0;
      e.legal = 1'b1;
      e.rs    = w[25:21];
      e.rt    = w[20:16];
      e.dest  = 5'd0;
      e.ctrl  = 4'b0;
      e.val   = 32'h0;
      a       = shadow[w[25:21]];
      rtv     = shadow[w[20:16]];
      se      = {{16{w[15]}}, w[15:0]};
      ze      = {16'h0, w[15:0]};
      e.a     = a;
      e.b     = rtv;
      case (w[31:26])
         6'h00: begin
            e.dest = w[15:11];
            case (w[5:0])
               6'h20: begin e.ctrl = 4'b0010; e.val = a + rtv; end
               6'h22: begin e.ctrl = 4'b0110; e.val = a - rtv; end
               6'h24: begin e.ctrl = 4'b0000; e.val = a & rtv; end
               6'h25: begin e.ctrl = 4'b0001; e.val = a | rtv; end
               6'h27: begin e.ctrl = 4'b1100; e.val = ~(a | rtv); end
               6'h2A: begin e.ctrl = 4'b0111; e.val = ($signed(a) < $signed(rtv)) ? 32'd1 : 32'd0; end
               default: e.legal = 1'b0;
            endcase
         end
         6'h08: begin e.dest = w[20:16]; e.b = se; e.ctrl = 4'b0010; e.val = a + se; end
         6'h0A: begin e.dest = w[20:16]; e.b = se; e.ctrl = 4'b0111;
                      e.val = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
         6'h0C: begin e.dest = w[20:16]; e.b = ze; e.ctrl = 4'b0000; e.val = a & ze; end
         6'h0D: begin e.dest = w[20:16]; e.b = ze; e.ctrl = 4'b0001; e.val = a | ze; end
         default: e.legal = 1'b0;
      endcase
      e.we = e.legal && (e.dest != 5'd0);
      return e;
   endfunction

   // Acceptor: records each handshake with the cycle in which it was offered.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (instr_valid && instr_ready) begin
            acc_e     = model(instr);
            acc_e.acc = cyc;
            q.push_back(acc_e);
            acc_log.push_back(cyc);
            n_acc++;
         end
         cyc++;
      end
   end

   // Monitor: checks outputs every cycle against the head expectation.
   always @(negedge clk) begin
      if (load_en) begin
         for (int i = 0; i < 32; i++) shadow[i] = init_vals[i];
      end
      if (!rst_n) begin
         chk("rst_ready", {31'b0, instr_ready}, 32'd1);
         chk("rst_outs", {31'b0, |{rf_r_reg1, rf_r_reg2, rf_w_reg, rf_w_data, rf_ctrl_w,
                                  alu_ctrl, alu_in1, alu_in2, done, illegal}}, 32'd0);
      end else if (q.size() == 0) begin
         chk("idle_ready", {31'b0, instr_ready}, 32'd1);
         chk("idle_outs", {31'b0, |{rf_r_reg1, rf_r_reg2, rf_w_reg, rf_w_data, rf_ctrl_w,
                                   alu_ctrl, alu_in1, alu_in2, done, illegal}}, 32'd0);
      end else begin
         int d;
         mon_h = q[0];
         d = cyc - mon_h.acc;
         chk("busy_ready", {31'b0, instr_ready}, 32'd0);
         if (!mon_h.legal) begin
            chk("ill_latency", d, 32'd1);
            chk("ill_done", {31'b0, done}, 32'd1);
            chk("ill_flag", {31'b0, illegal}, 32'd1);
            chk("ill_wen", {31'b0, rf_ctrl_w}, 32'd0);
            chk("ill_ports", {31'b0, |{rf_r_reg1, rf_r_reg2, alu_ctrl, alu_in1, alu_in2}}, 32'd0);
            $display("txn illegal acc=%0d done=%0d illegal=%0d", mon_h.acc, done, illegal);
            void'(q.pop_front());
         end else if (d == 1) begin
            chk("rd_reg1", {27'b0, rf_r_reg1}, {27'b0, mon_h.rs});
            chk("rd_reg2", {27'b0, rf_r_reg2}, {27'b0, mon_h.rt});
            chk("rd_quiet", {31'b0, |{alu_ctrl, alu_in1, alu_in2, done, rf_ctrl_w, illegal}}, 32'd0);
         end else if (d == 2) begin
            chk("ex_ctrl", {28'b0, alu_ctrl}, {28'b0, mon_h.ctrl});
            chk("ex_in1", alu_in1, mon_h.a);
            chk("ex_in2", alu_in2, mon_h.b);
            chk("ex_quiet", {31'b0, |{rf_r_reg1, rf_r_reg2, done, rf_ctrl_w, illegal}}, 32'd0);
         end else begin
            chk("wb_latency", d, 32'd3);
            chk("wb_done", {31'b0, done}, 32'd1);
            chk("wb_illegal", {31'b0, illegal}, 32'd0);
            chk("wb_wen", {31'b0, rf_ctrl_w}, {31'b0, mon_h.we});
            chk("wb_reg", {27'b0, rf_w_reg}, {27'b0, mon_h.dest});
            chk("wb_data", rf_w_data, mon_h.val);
            $display("txn wb acc=%0d dest=%0d data=%h wen=%0d", mon_h.acc, rf_w_reg, rf_w_data, rf_ctrl_w);
            if (mon_h.we) shadow[mon_h.dest] = mon_h.val;
            void'(q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      logic [4:0] sh;
      sh = 5'($urandom);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0]  fn_tab [6];
      logic [5:0]  op_tab [4];
      logic [4:0]  rs, rt, rd;
      logic [5:0]  op, fn;
      logic [15:0] imm;
      int          k;
      fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
      op_tab = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      k   = $urandom_range(0, 11);
      if (k < 6) return rtype(rs, rt, rd, fn_tab[k]);
      if (k < 10) return itype(op_tab[k-6], rs, rt, imm);
      if (k == 10) begin
         op = 6'($urandom);
         if (op inside {6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D}) op = 6'h3F;
         return {op, 26'($urandom)};
      end
      fn = 6'($urandom);
      if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A}) fn = 6'h21;
      return rtype(rs, rt, rd, fn);
   endfunction

   task automatic issue(input logic [31:0] w);
      int start;
      bit got;
      @(negedge clk);
      start       = n_acc;
      instr_valid = 1'b1;
      instr       = w;
      got         = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (n_acc != start) begin
            got = 1'b1;
            break;
         end
      end
      instr_valid = 1'b0;
      instr       = $urandom;
      chk("accept_timeout", {31'b0, got}, 32'd1);
   endtask

   initial begin
      logic [31:0] b2b [3];
      bit          got;
      int          base;

      for (int i = 0; i < 32; i++) init_vals[i] = (i == 0) ? 32'h0 : $urandom;
      load_en = 1'b1;
      repeat (2) @(negedge clk);
      #2 load_en = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Directed: set r1=2, r2=1, then the reference cases.
      issue(itype(6'h08, 5'd0, 5'd1, 16'd2));
      issue(itype(6'h08, 5'd0, 5'd2, 16'd1));
      issue(32'h00221820);   // add $3,$1,$2
      issue(32'h2024FFFF);   // addi $4,$1,-1
      issue(32'h34058000);   // ori $5,$0,0x8000
      issue(32'h00220020);   // add $0,$1,$2
      issue(32'hFC000000);   // opcode 0x3F

      // Reset asserted mid-EXEC of an add: aborted, nothing written.
      issue(rtype(5'd1, 5'd2, 5'd6, 6'h20));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_ready", {31'b0, instr_ready}, 32'd1);
      chk("async_rst_outs", {31'b0, |{rf_r_reg1, rf_r_reg2, rf_w_reg, rf_w_data, rf_ctrl_w,
                                     alu_ctrl, alu_in1, alu_in2, done, illegal}}, 32'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Back-to-back with valid held high and garbage offered while busy.
      b2b[0] = rtype(5'd1, 5'd2, 5'd7, 6'h20);
      b2b[1] = rtype(5'd7, 5'd1, 5'd8, 6'h22);
      b2b[2] = itype(6'h0D, 5'd8, 5'd9, 16'hF0F0);
      @(negedge clk);
      base = acc_log.size();
      instr_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         int start;
         start = n_acc;
         instr = b2b[j];
         got   = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (n_acc != start) begin
               got = 1'b1;
               break;
            end
         end
         chk("b2b_accept", {31'b0, got}, 32'd1);
         instr = 32'hFC000000 | 32'($urandom_range(0, 32'h03FF_FFFF));
         if (j < 2) repeat (2) @(negedge clk);
      end
      instr_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("b2b_count", acc_log.size() - base, 32'd3);
      if (acc_log.size() - base >= 3) begin
         chk("b2b_gap1", acc_log[base+1] - acc_log[base], 32'd4);
         chk("b2b_gap2", acc_log[base+2] - acc_log[base+1], 32'd4);
      end

      // Randomized mix, including illegal encodings and $0 destinations.
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(rand_instr());
      end

      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (q.size() == 0) begin
            got = 1'b1;
            break;
         end
      end
      chk("drain", {31'b0, got}, 32'd1);
      @(negedge clk);
      for (int i = 0; i < 32; i++) chk($sformatf("final_r%0d", i), regs[i], shadow[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
